// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rv32_pkg                                               |
// | Description : Shared constants and types for the RV32I fetch front  |
// |               end (data width, NOP encoding, reset PC, FSM states).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package rv32_pkg;

  localparam int c_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [c_XLEN-1:0] c_NOP_INSTR = 32'h0000_0013;
  localparam logic [c_XLEN-1:0] c_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_id_reg                                              |
// | Description : IF/ID output slot plus a one-entry hold buffer for a   |
// |               response that arrives while the slot is stalled.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module if_id_reg
  import rv32_pkg::*;
#(
  parameter logic [c_XLEN-1:0] NOP_INSTR = c_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_capture,
  input  logic              i_release,
  input  logic              i_stall,
  input  logic [c_XLEN-1:0] i_data,
  input  logic [c_XLEN-1:0] i_pc,
  output logic              o_valid,
  output logic [c_XLEN-1:0] o_instr,
  output logic [c_XLEN-1:0] o_pc
);

  logic              r_valid;
  logic [c_XLEN-1:0] r_instr;
  logic [c_XLEN-1:0] r_pc;
  logic              r_hold_valid;
  logic [c_XLEN-1:0] r_hold_instr;
  logic [c_XLEN-1:0] r_hold_pc;

  // Slot update priority: flush, fresh load, hold release, consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pc         <= '0;
      r_hold_valid <= 1'b0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= '0;
    end else if (i_flush) begin
      // A flush empties the slot even under stall.
      r_valid      <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_hold_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_instr <= i_data;
        r_pc    <= i_pc;
      end else if (i_release && r_hold_valid) begin
        r_valid      <= 1'b1;
        r_instr      <= r_hold_instr;
        r_pc         <= r_hold_pc;
        r_hold_valid <= 1'b0;
      end else if (r_valid && !i_stall) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
      if (i_capture) begin
        r_hold_valid <= 1'b1;
        r_hold_instr <= i_data;
        r_hold_pc    <= i_pc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_stage                                            |
// | Description : RV32I instruction fetch: PC, single-outstanding imem   |
// |               request FSM, redirect flush, stale-response dropping.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [c_XLEN-1:0] RESET_PC  = c_RESET_PC,
  parameter logic [c_XLEN-1:0] NOP_INSTR = c_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [c_XLEN-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [c_XLEN-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [c_XLEN-1:0] redirect_pc,
  input  logic              stall,
  output logic              instr_valid,
  output logic [c_XLEN-1:0] instruction,
  output logic [c_XLEN-1:0] instr_pc,
  output logic              misaligned_exc
);

  fetch_state_t      r_state;
  logic [c_XLEN-1:0] r_pc;
  logic [c_XLEN-1:0] r_req_addr;
  logic              r_drop;
  logic              r_misaligned;

  logic w_slot_valid;
  logic w_slot_blocked;
  logic w_handshake;
  logic w_redir_ok;
  logic w_redir_bad;
  logic w_rsp_take;
  logic w_load;
  logic w_capture;
  logic w_release;

  assign w_slot_blocked = w_slot_valid && stall;
  assign w_redir_ok     = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign w_redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);

  assign imem_req_valid = (r_state == FETCH) && !w_slot_blocked;
  assign imem_req_addr  = r_pc;
  assign w_handshake    = imem_req_valid && imem_req_ready;

  // A live response is one that is neither marked stale nor killed by a redirect.
  assign w_rsp_take = (r_state == WAIT) && imem_rsp_valid && !r_drop && !w_redir_ok;
  assign w_load     = w_rsp_take && !w_slot_blocked;
  assign w_capture  = w_rsp_take && w_slot_blocked;
  assign w_release  = (r_state == HOLD) && !stall && !w_redir_ok;

  // PC, request FSM and stale-response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= '0;
      r_drop       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      // Misaligned targets only raise the exception; the redirect itself is ignored.
      r_misaligned <= w_redir_bad;
      if (w_redir_ok) begin
        r_pc <= redirect_pc;
        case (r_state)
          FETCH: begin
            // Without a handshake nothing is in flight, so there is nothing to drop.
            if (w_handshake) begin
              r_drop  <= 1'b1;
              r_state <= WAIT;
            end else begin
              r_drop  <= 1'b0;
              r_state <= FETCH;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              r_drop  <= 1'b0;
              r_state <= FETCH;
            end else begin
              r_drop  <= 1'b1;
              r_state <= WAIT;
            end
          end
          default: begin
            r_drop  <= 1'b0;
            r_state <= FETCH;
          end
        endcase
      end else begin
        case (r_state)
          FETCH: begin
            if (w_handshake) begin
              r_req_addr <= r_pc;
              r_pc       <= r_pc + 32'd4;
              r_state    <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              if (r_drop) begin
                r_drop  <= 1'b0;
                r_state <= FETCH;
              end else if (!w_slot_blocked) begin
                r_state <= FETCH;
              end else begin
                r_state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              r_state <= FETCH;
            end
          end
          default: r_state <= FETCH;
        endcase
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (w_redir_ok),
    .i_load    (w_load),
    .i_capture (w_capture),
    .i_release (w_release),
    .i_stall   (stall),
    .i_data    (imem_rsp_data),
    .i_pc      (r_req_addr),
    .o_valid   (w_slot_valid),
    .o_instr   (instruction),
    .o_pc      (instr_pc)
  );

  assign instr_valid    = w_slot_valid;
  assign misaligned_exc = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_stage                                         |
// | Description : Directed self-checking bench for fetch_stage with a    |
// |               variable-latency memory model and a slot scoreboard.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fetch_stage;
  import rv32_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        misaligned_exc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          cnt;
  } pend_t;

  exp_t  sb[$];
  pend_t pend[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    g_lat   = 1;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .misaligned_exc (misaligned_exc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return 32'hA500_0000 ^ a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_rd(a);
    sb.push_back(e);
  endtask

  // Memory: accepted requests answer g_lat cycles later, out of order if latencies differ.
  initial begin
    logic        hs;
    logic [31:0] a;
    int          l;
    int          hit;
    pend_t       p;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready && !rst;
      a  = imem_req_addr;
      l  = g_lat;
      @(posedge clk);
      #1;
      if (hs) begin
        p.addr = a;
        p.cnt  = l;
        pend.push_back(p);
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      hit = -1;
      for (int i = 0; i < pend.size(); i++) begin
        pend[i].cnt = pend[i].cnt - 1;
        if (pend[i].cnt <= 0 && hit < 0) hit = i;
      end
      if (hit >= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_rd(pend[hit].addr);
        pend.delete(hit);
      end
    end
  end

  // Scoreboard: every consumed slot must match the next expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && !stall) begin
        n_tests++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed pc %h expected none", instr_pc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_pc", instr_pc, e.pc);
          chk("sb_instr", instruction, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; stall = 1'b0; g_lat = 1;
    nxt(); mid();
    chk("rst_iv", instr_valid, 0);
    chk("rst_instr", instruction, NOP);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_mis", misaligned_exc, 0);
    chk("rst_addr", imem_req_addr, 0);
    // Sequential fetch with 1-cycle memory
    nxt(); rst = 1'b0;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    mid(); chk("c0_rv", imem_req_valid, 1); chk("c0_addr", imem_req_addr, 32'h0);
    nxt(); mid(); chk("c1_rv", imem_req_valid, 0); chk("c1_iv", instr_valid, 0);
    nxt(); mid(); chk("c2_addr", imem_req_addr, 32'h4); chk("c2_iv", instr_valid, 1);
    chk("c2_ipc", instr_pc, 32'h0); chk("c2_instr", instruction, 32'h0050_0093);
    nxt(); mid(); chk("c3_iv", instr_valid, 0); chk("c3_instr", instruction, NOP);
    nxt(); mid(); chk("c4_addr", imem_req_addr, 32'h8); chk("c4_ipc", instr_pc, 32'h4);
    // Stall while response in flight, then frozen slot
    nxt(); stall = 1'b1; mid(); chk("c5_rv", imem_req_valid, 0);
    nxt(); mid(); chk("c6_iv", instr_valid, 1); chk("c6_ipc", instr_pc, 32'h8);
    chk("c6_rv", imem_req_valid, 0);
    nxt(); mid(); chk("c7_ipc", instr_pc, 32'h8); chk("c7_rv", imem_req_valid, 0);
    nxt(); stall = 1'b0; mid(); chk("c8_addr", imem_req_addr, 32'hC); chk("c8_rv", imem_req_valid, 1);
    nxt(); mid();
    nxt(); imem_req_ready = 1'b0; mid(); chk("c10_ipc", instr_pc, 32'hC); chk("c10_addr", imem_req_addr, 32'h10);
    nxt(); mid(); chk("c11_iv", instr_valid, 0); chk("c11_rv", imem_req_valid, 1);
    chk("c11_addr_held", imem_req_addr, 32'h10);
    // Redirect in WAIT, stale response arrives two cycles later
    nxt(); imem_req_ready = 1'b1; g_lat = 3; push_exp(32'h100); mid();
    chk("c12_addr", imem_req_addr, 32'h10);
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h100; mid(); chk("c13_rv", imem_req_valid, 0);
    nxt(); redirect_valid = 1'b0; g_lat = 1; mid(); chk("c14_rv", imem_req_valid, 0); chk("c14_iv", instr_valid, 0);
    nxt(); mid(); chk("c15_rv", imem_req_valid, 0); chk("c15_iv", instr_valid, 0);
    nxt(); mid(); chk("c16_addr", imem_req_addr, 32'h100); chk("c16_iv", instr_valid, 0);
    nxt(); mid();
    nxt(); push_exp(32'h200); mid(); chk("c18_ipc", instr_pc, 32'h100); chk("c18_addr", imem_req_addr, 32'h104);
    // Redirect coinciding with a response, under stall
    nxt(); stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; mid();
    nxt(); redirect_valid = 1'b0; mid(); chk("c20_iv", instr_valid, 0); chk("c20_instr", instruction, NOP);
    chk("c20_rv", imem_req_valid, 1); chk("c20_addr", imem_req_addr, 32'h200);
    nxt(); mid();
    nxt(); mid(); chk("c22_ipc", instr_pc, 32'h200); chk("c22_rv", imem_req_valid, 0);
    nxt(); mid(); chk("c23_iv", instr_valid, 1);
    nxt(); stall = 1'b0; push_exp(32'h204); push_exp(32'h208); mid(); chk("c24_addr", imem_req_addr, 32'h204);
    // Misaligned redirect
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h102; mid(); chk("c25_mis", misaligned_exc, 0);
    nxt(); redirect_valid = 1'b0; mid(); chk("c26_mis", misaligned_exc, 1);
    chk("c26_ipc", instr_pc, 32'h204); chk("c26_addr", imem_req_addr, 32'h208);
    nxt(); mid(); chk("c27_mis", misaligned_exc, 0);
    nxt(); imem_req_ready = 1'b0; mid(); chk("c28_ipc", instr_pc, 32'h208);
    // Reset in WAIT with a late response afterwards
    nxt(); imem_req_ready = 1'b1; g_lat = 4; mid(); chk("c29_addr", imem_req_addr, 32'h20C);
    nxt(); rst = 1'b1; g_lat = 1; mid();
    nxt(); rst = 1'b0; push_exp(32'h0); push_exp(32'h4); mid();
    chk("c31_addr", imem_req_addr, 32'h0); chk("c31_rv", imem_req_valid, 1);
    chk("c31_iv", instr_valid, 0); chk("c31_ipc", instr_pc, 32'h0);
    nxt(); mid();
    nxt(); mid(); chk("c33_ipc", instr_pc, 32'h0); chk("c33_addr", imem_req_addr, 32'h4);
    nxt(); mid(); chk("c34_iv", instr_valid, 0);
    nxt(); imem_req_ready = 1'b0; mid(); chk("c35_instr", instruction, 32'h00A0_0113);
    // PC wrap at the top of the address space
    nxt(); imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC); mid(); chk("c36_addr", imem_req_addr, 32'h8);
    nxt(); redirect_valid = 1'b0; mid(); chk("c37_rv", imem_req_valid, 0); chk("c37_iv", instr_valid, 0);
    nxt(); mid(); chk("c38_addr", imem_req_addr, 32'hFFFF_FFFC);
    nxt(); mid();
    nxt(); imem_req_ready = 1'b0; mid(); chk("c40_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("c40_wrap_addr", imem_req_addr, 32'h0);
    nxt(); mid(); chk("c41_iv", instr_valid, 0);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
